// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants and helpers for the seven-segment scan driver.
//   - Active-low glyph constants, ordered {a,b,c,d,e,f,g}.
//   - ANODE_OFF: level that switches an anode off (common-anode, so high).
//   - seg_decode(): 4-bit digit code to glyph, decimal or hex glyph set.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    // Decimal glyphs, active-low {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

    // Hex glyphs (A, b, C, d, E, F)
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b1100000;
    localparam logic [6:0] SEG_HEX_C = 7'b0110001;
    localparam logic [6:0] SEG_HEX_D = 7'b1000010;
    localparam logic [6:0] SEG_HEX_E = 7'b0110000;
    localparam logic [6:0] SEG_HEX_F = 7'b0111000;

    // Special glyphs of the decimal set
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;

    // Common-anode display: an anode bit at this level turns its digit off.
    // A fully dark display is every anode bit at ANODE_OFF.
    localparam logic ANODE_OFF = 1'b1;

    // Digit code to glyph. In decimal mode 1010..1110 are blank and 1111 is
    // a minus sign; in hex mode 1010..1111 are A..F.
    function automatic logic [6:0] seg_decode(input logic [3:0] code,
                                              input logic       hex_mode);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = hex_mode ? SEG_HEX_A : SEG_BLANK;
            4'd11:   seg = hex_mode ? SEG_HEX_B : SEG_BLANK;
            4'd12:   seg = hex_mode ? SEG_HEX_C : SEG_BLANK;
            4'd13:   seg = hex_mode ? SEG_HEX_D : SEG_BLANK;
            4'd14:   seg = hex_mode ? SEG_HEX_E : SEG_BLANK;
            4'd15:   seg = hex_mode ? SEG_HEX_F : SEG_MINUS;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver_if
// Bundles the value/control inputs from the datapath and the display pins.
//   en         display enable (low blanks all anodes)
//   lzs        leading-zero suppression enable
//   num        packed digit codes, digit i at [4i+3:4i], digit 0 rightmost
//   dp         decimal point request per digit, 1 = lit
//   segments   {a,b,c,d,e,f,g}, active-low
//   dp_n       decimal point segment, active-low
//   anode      one-cold digit select, active-low
//   frame_done one-cycle pulse on the snapshot cycle
// Modports: master = datapath/board side, slave = scan driver.
// -----------------------------------------------------------------------------
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    lzs;
    logic [4*NUM_DIGITS-1:0] num;
    logic [NUM_DIGITS-1:0]   dp;
    logic [6:0]              segments;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    frame_done;

    modport master (
        output en, lzs, num, dp,
        input  segments, dp_n, anode, frame_done
    );

    modport slave (
        input  en, lzs, num, dp,
        output segments, dp_n, anode, frame_done
    );
endinterface

// File: rtl/seven_seg_glyph.sv
// -----------------------------------------------------------------------------
// seven_seg_glyph
// Purely combinational 4-bit code to active-low seven-segment glyph.
//   HEX_MODE  1: codes 1010..1111 show A..F; 0: blank / minus glyph set
//   code      in  4  digit code
//   segments  out 7  {a,b,c,d,e,f,g}, active-low
// -----------------------------------------------------------------------------
module seven_seg_glyph
    import seven_seg_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] code,
    output logic [6:0] segments
);

    localparam logic HEX_SEL = (HEX_MODE != 0) ? 1'b1 : 1'b0;

    // Table lookup; the helper covers every code so the output is always defined
    always_comb begin
        segments = SEG_BLANK;
        segments = seg_decode(code, HEX_SEL);
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexed common-anode seven-segment driver. A prescaler divides the
// clock into digit slots; the digit index walks 0..NUM_DIGITS-1. At the end of
// the last slot of a frame the input value, decimal points and leading-zero
// blank mask are snapshotted, so a frame never mixes old and new digits.
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   bus.en      in   display enable
//   bus.lzs     in   leading-zero suppression (taken at snapshot)
//   bus.num     in   4*NUM_DIGITS digit codes
//   bus.dp      in   NUM_DIGITS decimal point requests
//   bus.segments out 7 active-low segments, registered
//   bus.dp_n    out  active-low decimal point, registered
//   bus.anode   out  one-cold active-low digit select, registered
//   bus.frame_done out pulse during the snapshot cycle
// -----------------------------------------------------------------------------
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2,
    parameter int HEX_MODE     = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    seven_seg_scan_driver_if.slave        bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_DARK = {NUM_DIGITS{ANODE_OFF}};
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    // Scan state
    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;

    // Frame snapshot
    logic [4*NUM_DIGITS-1:0] snap_num_r;
    logic [NUM_DIGITS-1:0]   snap_dp_r;
    logic [NUM_DIGITS-1:0]   blank_mask_r;

    // Output registers
    logic [6:0]              segments_r;
    logic                    dp_n_r;
    logic [NUM_DIGITS-1:0]   anode_r;

    // Combinational helpers
    logic                    tc_s;
    logic                    snap_s;
    logic                    guard_s;
    logic [3:0]              code_s;
    logic [6:0]              glyph_s;
    logic [NUM_DIGITS-1:0]   blank_mask_s;
    logic                    zero_run_s;
    logic [6:0]              seg_next_s;
    logic                    dp_n_next_s;
    logic [NUM_DIGITS-1:0]   anode_next_s;

    assign tc_s   = (cnt_r == CNT_LAST);
    assign snap_s = tc_s && (idx_r == IDX_LAST);

    // Guard window: the first GUARD_CYCLES of every slot keep all anodes dark
    // so the previous digit's segments cannot ghost onto the new digit.
    generate
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign guard_s = 1'b0;
        end else begin : g_guard
            assign guard_s = (cnt_r < CNT_W'(GUARD_CYCLES));
        end
    endgenerate

    // Digit currently being scanned, taken from the frame snapshot
    assign code_s = snap_num_r[{idx_r, 2'b00} +: 4];

    seven_seg_glyph #(
        .HEX_MODE (HEX_MODE)
    ) u_glyph (
        .code     (code_s),
        .segments (glyph_s)
    );

    // Leading-zero mask from the live inputs: a running "all zero so far"
    // flag walks down from the top digit; digit 0 is never blanked.
    always_comb begin
        blank_mask_s = '0;
        zero_run_s   = bus.lzs;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run_s      = zero_run_s & (bus.num[4*i +: 4] == 4'd0);
            blank_mask_s[i] = zero_run_s;
        end
    end

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (tc_s) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_LAST) ? '0 : (idx_r + IDX_W'(1));
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            idx_r <= idx_r;
        end
    end

    // Frame snapshot, taken once per frame at the end of the last slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_num_r   <= '0;
            snap_dp_r    <= '0;
            blank_mask_r <= '0;
        end else if (snap_s) begin
            snap_num_r   <= bus.num;
            snap_dp_r    <= bus.dp;
            blank_mask_r <= blank_mask_s;
        end else begin
            snap_num_r   <= snap_num_r;
            snap_dp_r    <= snap_dp_r;
            blank_mask_r <= blank_mask_r;
        end
    end

    // Next output values; en low darkens everything but scanning continues.
    // Segments keep the slot's glyph during the guard, only anodes go dark.
    always_comb begin
        seg_next_s   = SEG_BLANK;
        dp_n_next_s  = 1'b1;
        anode_next_s = ANODE_DARK;
        if (bus.en) begin
            seg_next_s  = blank_mask_r[idx_r] ? SEG_BLANK : glyph_s;
            dp_n_next_s = ~snap_dp_r[idx_r];
            if (guard_s) begin
                anode_next_s = ANODE_DARK;
            end else begin
                anode_next_s = ~(ONE_HOT0 << idx_r);
            end
        end else begin
            seg_next_s   = SEG_BLANK;
            dp_n_next_s  = 1'b1;
            anode_next_s = ANODE_DARK;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments_r <= SEG_BLANK;
            dp_n_r     <= 1'b1;
            anode_r    <= ANODE_DARK;
        end else begin
            segments_r <= seg_next_s;
            dp_n_r     <= dp_n_next_s;
            anode_r    <= anode_next_s;
        end
    end

    assign bus.segments   = segments_r;
    assign bus.dp_n       = dp_n_r;
    assign bus.anode      = anode_r;
    // Decoded straight from registered scan state, so it marks the snapshot
    // cycle itself and drops to 0 as soon as reset clears the counters.
    assign bus.frame_done = snap_s;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
// Two instances (decimal and hex glyph sets) driven with the same stimulus.
// A reference model steps once per clock, pushes the expected outputs into a
// queue, and a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int G     = 1;
    localparam int FRAME = N * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic            en_drv  = 1'b0;
    logic            lzs_drv = 1'b0;
    logic [4*N-1:0]  num_drv = '0;
    logic [N-1:0]    dp_drv  = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus0 ();
    seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus1 ();

    assign bus0.en  = en_drv;
    assign bus0.lzs = lzs_drv;
    assign bus0.num = num_drv;
    assign bus0.dp  = dp_drv;
    assign bus1.en  = en_drv;
    assign bus1.lzs = lzs_drv;
    assign bus1.num = num_drv;
    assign bus1.dp  = dp_drv;

    seven_seg_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(G), .HEX_MODE(0)
    ) dut_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(G), .HEX_MODE(1)
    ) dut_hex (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Glyph tables written straight from the display rules
    logic [6:0] dec_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
                                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111110};
    logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    typedef struct {
        logic [N-1:0] anode;
        logic [6:0]   seg_dec;
        logic [6:0]   seg_hex;
        logic         dp_n;
        logic         fd;
        logic         seg_chk;
    } exp_t;

    exp_t q[$];

    // Count the zero digits at the top (digit 0 excluded) and mark them
    function automatic logic [N-1:0] lz_mask(input logic [4*N-1:0] v, input logic on);
        logic [N-1:0] m;
        int k;
        m = '0;
        k = 0;
        if (on) begin
            while (k < N - 1 && ((v >> (4 * (N - 1 - k))) & 16'hF) == 0) begin
                m[N - 1 - k] = 1'b1;
                k++;
            end
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed cycles since reset decide slot and phase
    initial begin : model
        int t;
        int slot;
        int phase;
        int digit;
        logic [4*N-1:0] m_num;
        logic [N-1:0]   m_dp;
        logic [N-1:0]   m_mask;
        exp_t e;
        t = 0; m_num = '0; m_dp = '0; m_mask = '0;
        forever begin
            @(posedge clk);
            e.anode = '1; e.seg_dec = 7'h7F; e.seg_hex = 7'h7F;
            e.dp_n = 1'b1; e.fd = 1'b0; e.seg_chk = 1'b1;
            if (!rst_n) begin
                t = 0; m_num = '0; m_dp = '0; m_mask = '0;
            end else begin
                slot  = (t / DIV) % N;
                phase = t % DIV;
                if (en_drv) begin
                    digit     = int'((m_num >> (4 * slot)) & 16'hF);
                    e.anode   = (phase < G) ? 4'hF : (4'hF ^ (4'd1 << slot));
                    e.seg_dec = m_mask[slot] ? 7'h7F : dec_tab[digit];
                    e.seg_hex = m_mask[slot] ? 7'h7F : hex_tab[digit];
                    e.dp_n    = !m_dp[slot];
                    e.seg_chk = (phase >= G);
                end
                if (t % FRAME == FRAME - 1) begin
                    m_num  = num_drv;
                    m_dp   = dp_drv;
                    m_mask = lz_mask(num_drv, lzs_drv);
                end
                t++;
                e.fd = (t % FRAME == FRAME - 1);
            end
            q.push_back(e);
        end
    end

    // Monitor: compare registered outputs away from the active edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL queue_empty actual=0 required=1 at %0t", $time);
            end else begin
                e = q.pop_front();
                if (!rst_n) begin
                    e.anode = '1; e.seg_dec = 7'h7F; e.seg_hex = 7'h7F;
                    e.dp_n = 1'b1; e.fd = 1'b0; e.seg_chk = 1'b1;
                end
                check("anode_dec", 7'(bus0.anode), 7'(e.anode));
                check("anode_hex", 7'(bus1.anode), 7'(e.anode));
                check("dp_n_dec", 7'(bus0.dp_n), 7'(e.dp_n));
                check("frame_done", 7'(bus0.frame_done), 7'(e.fd));
                check("frame_done_hex", 7'(bus1.frame_done), 7'(e.fd));
                if (e.seg_chk) begin
                    check("seg_dec", bus0.segments, e.seg_dec);
                    check("seg_hex", bus1.segments, e.seg_hex);
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus
    initial begin : stim
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        en_drv  = 1'b1;
        num_drv = 16'h1234;
        run(40);

        // Leading-zero suppression
        num_drv = 16'h0070; lzs_drv = 1'b1;
        run(36);
        num_drv = 16'h0000;
        run(36);

        // Tearing: change value in the middle of a frame
        lzs_drv = 1'b0; num_drv = 16'h1111;
        run(37);
        num_drv = 16'h2222;
        run(30);

        // Enable and decimal points
        en_drv = 1'b0;
        run(10);
        en_drv = 1'b1; dp_drv = 4'b0100;
        run(36);

        // Glyph sets
        dp_drv = '0; num_drv = 16'hFA0B;
        run(36);

        // Asynchronous reset pulse mid-slot
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_anode", 7'(bus0.anode), 7'h0F);
        check("async_seg", bus0.segments, 7'h7F);
        check("async_seg_hex", bus1.segments, 7'h7F);
        check("async_dp_n", 7'(bus0.dp_n), 7'h01);
        check("async_fd", 7'(bus0.frame_done), 7'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(24);

        // Randomized phase, biased towards zero digits
        for (int it = 0; it < 30; it++) begin
            logic [4*N-1:0] v;
            v = '0;
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(0, 2) != 0) v[4*d +: 4] = 4'($urandom_range(0, 15));
            end
            num_drv = v;
            dp_drv  = N'($urandom_range(0, 15));
            lzs_drv = 1'($urandom_range(0, 1));
            en_drv  = ($urandom_range(0, 7) != 0);
            run($urandom_range(1, 40));
        end

        run(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
